// File: rtl/wash_cycle_sched.sv
// Washer cycle scheduler: sequences fill/wash/drain/rinse/spin from a load mode,
// drives valves and motor, and reports phase plus BCD remaining seconds.
module wash_cycle_sched #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned FILL_TMO  = 30,
  parameter int unsigned DRAIN_TMO = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic       lid_closed,
  input  logic       level_full,
  input  logic       level_empty,
  output logic       valve_in,
  output logic       valve_out,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic [1:0] phase,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones,
  output logic       done,
  output logic       fault
);

  localparam int unsigned   TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [5:0]    FILL_LAST  = 6'(FILL_TMO - 1);
  localparam logic [5:0]    DRAIN_LAST = 6'(DRAIN_TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL1, S_WASH, S_DRAIN1, S_FILL2, S_RINSE,
    S_DRAIN2, S_SPIN, S_DONE, S_PAUSE, S_FAULT
  } state_t;

  function automatic logic [5:0] phase_sec(input logic [1:0] m);
    case (m)
      2'b01:   return 6'd10;
      2'b11:   return 6'd20;
      default: return 6'd15;
    endcase
  endfunction

  function automatic logic [5:0] total_sec(input logic [1:0] m);
    case (m)
      2'b00:   return 6'd15;
      2'b01:   return 6'd30;
      2'b10:   return 6'd45;
      default: return 6'd60;
    endcase
  endfunction

  state_t        r_state, r_saved, w_next, w_ph_state;
  logic [TW-1:0] r_tick;
  logic [5:0]    r_timer, r_elapsed, r_remain, w_remain_nxt, w_sec;
  logic [3:0]    r_tens, r_ones;
  logic [1:0]    r_mode, w_el;
  logic          r_start_d;
  logic          w_start_edge, w_accept, w_run, w_timed, w_next_timed;
  logic          w_pause_req, w_go_pause, w_tick, w_enter;

  assign w_start_edge = start && !r_start_d;
  assign w_accept     = (r_state == S_IDLE) && w_start_edge && lid_closed;
  assign w_run        = (r_state >= S_FILL1) && (r_state <= S_SPIN);
  assign w_timed      = (r_state == S_WASH) || (r_state == S_RINSE) || (r_state == S_SPIN);
  assign w_next_timed = (w_next == S_WASH) || (w_next == S_RINSE) || (w_next == S_SPIN);
  assign w_pause_req  = pause || !lid_closed;
  assign w_go_pause   = w_run && w_pause_req;
  assign w_tick       = w_run && !w_pause_req && (r_tick == TICK_LAST);
  // PAUSE entry/exit is not a state entry: tick, timer and elapsed all hold across it.
  assign w_enter      = (w_next != r_state) && (r_state != S_PAUSE) && (w_next != S_PAUSE);
  assign w_sec        = phase_sec(r_mode);
  assign w_el         = w_sec[1:0] - r_timer[1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (mode == 2'b00) ? S_SPIN : S_FILL1;
      S_DONE:  if (w_start_edge) w_next = S_IDLE;
      S_PAUSE: if (!pause && lid_closed) w_next = r_saved;
      S_FAULT: w_next = S_FAULT;
      default: begin
        if (w_pause_req) w_next = S_PAUSE;
        else begin
          case (r_state)
            S_FILL1:  if (level_full) w_next = S_WASH;
                      else if (w_tick && r_elapsed == FILL_LAST) w_next = S_FAULT;
            S_FILL2:  if (level_full) w_next = S_RINSE;
                      else if (w_tick && r_elapsed == FILL_LAST) w_next = S_FAULT;
            S_DRAIN1: if (level_empty) w_next = S_FILL2;
                      else if (w_tick && r_elapsed == DRAIN_LAST) w_next = S_FAULT;
            S_DRAIN2: if (level_empty) w_next = S_SPIN;
                      else if (w_tick && r_elapsed == DRAIN_LAST) w_next = S_FAULT;
            S_WASH:   if (w_tick && r_timer <= 6'd1) w_next = S_DRAIN1;
            S_RINSE:  if (w_tick && r_timer <= 6'd1) w_next = S_DRAIN2;
            S_SPIN:   if (w_tick && r_timer <= 6'd1) w_next = S_DONE;
            default:  w_next = r_state;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_remain_nxt = r_remain;
    if (w_accept) w_remain_nxt = total_sec(mode);
    else if (w_tick && w_timed && r_remain != '0) w_remain_nxt = r_remain - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_saved   <= S_IDLE;
      r_tick    <= '0;
      r_timer   <= '0;
      r_elapsed <= '0;
      r_remain  <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_mode    <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_d <= start;
      r_remain  <= w_remain_nxt;
      r_tens    <= 4'(w_remain_nxt / 6'd10);
      r_ones    <= 4'(w_remain_nxt % 6'd10);
      if (w_go_pause) r_saved <= r_state;
      if (w_accept) r_mode <= mode;
      if (w_enter || w_tick) r_tick <= '0;
      else if (w_run && !w_pause_req) r_tick <= r_tick + 1'b1;
      if (w_accept) r_timer <= phase_sec(mode);
      else if (w_enter && w_next_timed) r_timer <= w_sec;
      else if (w_tick && w_timed) r_timer <= r_timer - 6'd1;
      if (w_enter) r_elapsed <= '0;
      else if (w_tick && !w_timed) r_elapsed <= r_elapsed + 6'd1;
    end
  end

  assign w_ph_state = (r_state == S_PAUSE) ? r_saved : r_state;

  always_comb begin
    valve_in  = 1'b0;
    valve_out = 1'b0;
    motor_fwd = 1'b0;
    motor_rev = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    phase     = 2'b00;
    case (w_ph_state)
      S_FILL1, S_WASH, S_DRAIN1:  phase = 2'b01;
      S_FILL2, S_RINSE, S_DRAIN2: phase = 2'b10;
      S_SPIN, S_DONE:             phase = 2'b11;
      default:                    phase = 2'b00;
    endcase
    case (r_state)
      S_FILL1, S_FILL2:   valve_in  = 1'b1;
      S_DRAIN1, S_DRAIN2: valve_out = 1'b1;
      S_WASH:  begin motor_fwd = !w_el[0]; motor_rev = w_el[0]; end
      S_RINSE: begin motor_fwd = !w_el[1]; motor_rev = w_el[1]; end
      S_SPIN:  begin motor_fwd = 1'b1; valve_out = 1'b1; end
      S_DONE:  done  = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign remain_tens = (r_state == S_FAULT) ? '0 : r_tens;
  assign remain_ones = (r_state == S_FAULT) ? '0 : r_ones;

endmodule
